// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
//   state_t       - sequencer state (IDLE, WAIT, FLUSH)
//   fetch_entry_t - one buffered fetch result {pc, instr}
//   INSTR_BYTES   - PC increment per instruction
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of fetch_entry_t, registered storage.
//   clock, reset     - rising-edge clock, async active-high reset
//   push, push_data  - write one entry (ignored when full without a pop)
//   pop              - retire head (ignored when empty)
//   flush            - drop all entries; has priority over push/pop
//   head             - current head entry
//   full, empty      - occupancy flags
//   count            - number of valid entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer in front of the icache.
//   clock, reset            - rising-edge clock, async active-high reset
//   imem_req, imem_addr     - registered fetch request (one outstanding)
//   imem_ack, imem_rdata    - icache response strobe and data
//   out_valid/ready/instr/pc - buffered {pc, instr} stream to decode
//   redirect_valid/pc       - one-cycle redirect from execute
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n, addr_n, pc_inc, tgt;
    logic          req_n;
    logic          push, pop, flush, full, empty;
    logic [CW-1:0] count, count_ap;
    logic          room_idle, room_ack;
    fetch_entry_t  head;

    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    assign tgt    = redirect_pc & ~32'h3;
    assign pc_inc = pc + 32'(INSTR_BYTES);

    // Occupancy after this cycle's pop decides whether a new fetch may go out,
    // so a slot is always reserved for the response of any request in flight.
    assign count_ap  = count - CW'(pop);
    assign room_idle = !full || pop;
    assign room_ack  = ({1'b0, count_ap} + (CW+1)'(1)) < (CW+1)'(DEPTH);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imem_req;
        addr_n  = imem_addr;
        push    = 1'b0;
        flush   = redirect_valid;
        unique case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_n    = tgt;
                    req_n   = 1'b1;
                    addr_n  = tgt;
                    state_n = WAIT;
                end else if (room_idle) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_n = tgt;
                    // Acked word is stale: drop it and re-aim the live request.
                    if (imem_ack) addr_n = tgt;
                    else          state_n = FLUSH;
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_n = pc_inc;
                    if (room_ack) begin
                        addr_n = pc_inc;
                    end else begin
                        req_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            FLUSH: begin
                // Request stays up until the stale response drains; its data is
                // never pushed. A redirect coinciding with that ack re-aims directly.
                if (redirect_valid) begin
                    pc_n = tgt;
                    if (imem_ack) begin
                        addr_n  = tgt;
                        state_n = WAIT;
                    end
                end else if (imem_ack) begin
                    addr_n  = pc;
                    state_n = WAIT;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: pc, instr: imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl. The reference model is a
// queue of expected {pc, instr} plus a running model pc; a separate monitor
// pops and compares whenever decode consumes an entry.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, out_valid, out_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, redirect_pc;

    always #5 clock = ~clock;

    fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_chk = 0, n_fail = 0, pops = 0;
    fetch_entry_t exp_q[$];
    logic [31:0] model_pc, addr_s, rpc_d, rdata_d;
    bit busy, stale, ack_d, redir_d, mon_en, found;
    int dly, p_redir, p_ready, max_dly;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: runs away from the active edge, consumes expectations on pop.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_pc", 64'(out_pc), 64'(e.pc));
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                    pops++;
                end
            end
        end
    end

    // One clock of stimulus: apply the model effects of the edge just passed,
    // act as the icache, then drive inputs for the next edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (ack_d) begin
            if (!redir_d && !stale) begin
                check("imem_addr", 64'(addr_s), 64'(model_pc));
                exp_q.push_back('{pc: model_pc, instr: rdata_d});
                model_pc += 32'd4;
            end
            busy  = 0;
            stale = 0;
        end
        if (redir_d) begin
            exp_q.delete();
            model_pc = {rpc_d[31:2], 2'b00};
            if (busy) stale = 1;
        end
        if (exp_q.size() > DEPTH)
            check("overfill", 64'(exp_q.size()), 64'(DEPTH));
        if (busy) begin
            check("imem_req held", 64'(imem_req), 64'd1);
            check("imem_addr held", 64'(imem_addr), 64'(addr_s));
        end else if (imem_req) begin
            busy   = 1;
            addr_s = imem_addr;
            dly    = $urandom_range(max_dly, 0);
        end
        ack_d = busy && dly == 0;
        if (busy && dly > 0) dly--;
        rdata_d    = $urandom;
        imem_ack   = ack_d;
        imem_rdata = rdata_d;
        redir_d    = $urandom_range(99, 0) < p_redir;
        case ($urandom_range(3, 0))
            0:       rpc_d = 32'h13;
            1:       rpc_d = 32'h40;
            2:       rpc_d = 32'hFFFF_FFF0 | $urandom_range(15, 0);
            default: rpc_d = $urandom_range(255, 0);
        endcase
        redirect_valid = redir_d;
        redirect_pc    = rpc_d;
        out_ready      = $urandom_range(99, 0) < p_ready;
    endtask

    // Async reset mid-cycle with an ack pulse during reset; optionally a
    // stray ack on the first cycle after release (DUT is IDLE then).
    task automatic do_reset(bit stray);
        mon_en = 0;
        @(negedge clock);
        #2;
        reset = 1; imem_ack = 0; redirect_valid = 0; out_ready = 0;
        #1;
        check("rst imem_req", 64'(imem_req), 64'd0);
        check("rst imem_addr", 64'(imem_addr), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_pc", 64'(out_pc), 64'd0);
        check("rst out_instr", 64'(out_instr), 64'd0);
        @(negedge clock);
        imem_ack = 1; imem_rdata = $urandom;
        @(negedge clock);
        imem_ack = 0;
        exp_q.delete();
        model_pc = RESET_PC;
        busy = 0; stale = 0; ack_d = 0; redir_d = 0;
        @(negedge clock);
        reset = 0; imem_ack = stray; mon_en = 1;
    endtask

    initial begin
        reset = 1; imem_ack = 0; imem_rdata = 0; out_ready = 0;
        redirect_valid = 0; redirect_pc = 0; mon_en = 0;
        p_redir = 0; p_ready = 100; max_dly = 0;

        // Streaming: single-cycle acks, decode always ready.
        do_reset(0);
        pops = 0;
        repeat (40) step();
        check("throughput", 64'(pops >= 35), 64'd1);

        // Back-pressure: buffer fills with two entries and fetch stops.
        do_reset(0);
        p_ready = 0;
        repeat (12) step();
        check("req drops when full", 64'(imem_req), 64'd0);
        check("full head pc", 64'(out_pc), 64'(RESET_PC));
        check("full valid", 64'(out_valid), 64'd1);
        p_ready = 100;
        repeat (10) step();

        // Random traffic with redirects, delayed acks and stalls.
        p_redir = 8; p_ready = 60; max_dly = 3; pops = 0;
        repeat (1500) step();
        check("random progress", 64'(pops > 200), 64'd1);

        // Reset while a request is outstanding, then a stray ack in IDLE.
        p_redir = 0; found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (busy && !ack_d) found = 1;
        end
        check("mid-wait reached", 64'(found), 64'd1);
        do_reset(1);
        p_ready = 100; max_dly = 1; pops = 0;
        repeat (20) step();
        check("restart progress", 64'(pops >= 5), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer placed in front of the instruction cache (icache).
- Owns the program counter and issues word-aligned fetch requests to the icache over a req/ack handshake, with at most one request outstanding.
- Buffers returned instructions in a small FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects, including discarding the response of an in-flight stale request.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, fetch-buffer entries (power of two, ≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_req  out  1  fetch request to icache; registered.
- imem_addr  out  32  fetch byte address; bits [1:0] always 0; registered.
- imem_ack  in  1  icache response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  returned instruction word.
- out_valid  out  1  buffer head valid to decode.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- redirect_valid  in  1  one-cycle redirect strobe from execute.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async): pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=0; FIFO empty; out_valid=0; out_instr=0; out_pc=0.
- Pop: occurs when out_valid && out_ready. FIFO count is evaluated after the same-cycle pop.
- room: true when (count_after_pop + pushes_this_cycle) < DEPTH.
- State IDLE:
  - If room and not redirect: next edge sets imem_req=1 and imem_addr=pc, then go to WAIT.
- State WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On ack: push {pc, imem_rdata}; pc+=4.
  - If room remains after the push: next cycle imem_req stays 1 with imem_addr=new pc (back-to-back, 1 instr/cycle with single-cycle ack).
  - Otherwise: imem_req=0 and go to IDLE.
- State FLUSH:
  - Entered from WAIT on a redirect without a same-cycle ack.
  - imem_req is held until ack; rdata is discarded, nothing is pushed.
  - Next cycle: issue request to the redirected pc and go to WAIT.
- Redirect has the highest priority:
  - FIFO is cleared, so out_valid=0 the next cycle. A same-cycle pop still completes.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - In IDLE: request to the new pc is issued the next cycle.
  - In WAIT with a same-cycle ack: response discarded; request to the new pc is issued the next cycle (imem_addr updates, imem_req stays 1).
  - In WAIT without ack: go to FLUSH.
  - In FLUSH: pc is updated, remain in FLUSH.
- FIFO:
  - Full: no request issued; an in-flight response always has a reserved slot.
  - Empty: out_valid=0.
  - Simultaneous push and pop on a full FIFO is legal (count unchanged).
  - Pointers wrap modulo DEPTH.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: first out_valid is asserted 1 cycle after the first imem_ack (registered FIFO output).
- Reset asserted mid-request: immediate return to the reset state; any later ack while in IDLE is ignored.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, WAIT, FLUSH};
  - fetch_entry_t struct {pc[31:0], instr[31:0]};
  - constant INSTR_BYTES=4.
- Sub-module fetch_fifo (DEPTH × fetch_entry_t):
  - push/pop/flush inputs; full/empty/count outputs;
  - same async reset.

Test Plan:
- Reset release, icache acks one cycle after each req, out_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8…; out_pc/out_instr match icache words; one instr per cycle after fill.
- out_ready=0 held -> exactly DEPTH=2 entries fetched (0x0, 0x4); imem_req drops; raising out_ready resumes fetching at 0x8.
- Redirect to 0x13 while WAIT with ack delayed 3 cycles -> FLUSH; stale rdata not delivered; next imem_addr=0x10; first out_pc=0x10.
- Redirect to 0x40 in the same cycle as imem_ack -> acked word dropped; out_valid=0 next cycle; next imem_addr=0x40.
- Redirect with full FIFO and out_ready=1 same cycle -> head is consumed once; other entry flushed; fetch restarts at redirect target.
- Reset asserted mid-WAIT, later ack pulse -> all outputs at reset values; no push; fetch restarts at RESET_PC.
